// File: rtl/multiplier_pkg.sv
// Shared widths and limits for the 4x4 unsigned array multiplier.
package multiplier_pkg;
  localparam int OPERAND_W   = 4;
  localparam int PRODUCT_W   = 8;
  localparam int MAX_PRODUCT = 225;

  typedef logic [OPERAND_W-1:0] operand_t;
  typedef logic [PRODUCT_W-1:0] product_t;
endpackage

// File: rtl/multiplier_4_bit_unsigned_full_adder.sv
// Gate-level full adder; one instance per adder-array cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/multiplier_4_bit_unsigned.sv
// Registered 4x4 unsigned array multiplier: AND partial products, three
// rows of ripple adders, and an output register that loads on i_valid.
module multiplier_4_bit_unsigned
  import multiplier_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [OPERAND_W-1:0] i_au,
  input  logic [OPERAND_W-1:0] i_bu,
  input  logic                 i_valid,
  output logic [PRODUCT_W-1:0] o_fu,
  output logic                 o_valid
);
  // Handshake: valid-only, no ready. An operand pair with i_valid=1 at a
  // rising edge is reflected on o_fu with o_valid=1 after that edge.

  logic [OPERAND_W-1:0] w_pp [0:OPERAND_W-1];
  logic [OPERAND_W-1:0] w_x  [1:OPERAND_W-1];
  logic [OPERAND_W-1:0] w_s  [1:OPERAND_W-1];
  logic [OPERAND_W:0]   w_c  [1:OPERAND_W-1];
  product_t             w_product;
  product_t             r_fu;
  logic                 r_valid;

  genvar j, k;
  generate
    for (j = 0; j < OPERAND_W; j++) begin : g_pp
      assign w_pp[j] = i_au & {OPERAND_W{i_bu[j]}};
    end

    // Row r adds pp[r] to the upper bits of the running sum; its LSB is
    // product bit r and the rest shift down into the next row.
    for (j = 1; j < OPERAND_W; j++) begin : g_row
      if (j == 1) begin : g_first
        assign w_x[j] = {1'b0, w_pp[0][OPERAND_W-1:1]};
      end else begin : g_next
        assign w_x[j] = {w_c[j-1][OPERAND_W], w_s[j-1][OPERAND_W-1:1]};
      end
      assign w_c[j][0] = 1'b0;
      for (k = 0; k < OPERAND_W; k++) begin : g_cell
        full_adder u_fa (
          .a    (w_x[j][k]),
          .b    (w_pp[j][k]),
          .cin  (w_c[j][k]),
          .s    (w_s[j][k]),
          .cout (w_c[j][k+1])
        );
      end
    end
  endgenerate

  assign w_product = {w_c[OPERAND_W-1][OPERAND_W],
                      w_s[3][3:1], w_s[3][0], w_s[2][0], w_s[1][0],
                      w_pp[0][0]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fu    <= '0;
      r_valid <= 1'b0;
    end else if (i_valid) begin
      r_fu    <= w_product;
      r_valid <= 1'b1;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign o_fu    = r_fu;
  assign o_valid = r_valid;
endmodule

// File: tb/tb_multiplier_4_bit_unsigned.sv
// Self-checking bench for multiplier_4_bit_unsigned: directed cases plus
// exhaustive and random operand streams against an arithmetic model.
module tb_multiplier_4_bit_unsigned;
  logic       i_clk;
  logic       i_rst;
  logic [3:0] i_au;
  logic [3:0] i_bu;
  logic       i_valid;
  logic [7:0] o_fu;
  logic       o_valid;

  int n_cmp;
  int n_bad;
  logic [7:0] exp_q[$];
  logic [7:0] m_fu;
  logic       m_v;

  multiplier_4_bit_unsigned dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_au    (i_au),
    .i_bu    (i_bu),
    .i_valid (i_valid),
    .o_fu    (o_fu),
    .o_valid (o_valid)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model, and check both outputs.
  task automatic step(input string tag, input logic [3:0] a,
                      input logic [3:0] b, input logic v, input logic r);
    logic [7:0] prod;
    i_au    = a;
    i_bu    = b;
    i_valid = v;
    i_rst   = r;
    prod = 8'(int'(a) * int'(b));
    if (!r && v) exp_q.push_back(prod);
    @(posedge i_clk);
    #1;
    if (r) begin
      m_fu = 8'h00;
      m_v  = 1'b0;
    end else if (v) begin
      m_fu = exp_q.pop_front();
      m_v  = 1'b1;
    end else begin
      m_v  = 1'b0;
    end
    check_eq({tag, "_valid"}, {31'b0, o_valid}, {31'b0, m_v});
    check_eq({tag, "_fu"}, {24'b0, o_fu}, {24'b0, m_fu});
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    m_fu    = 8'h00;
    m_v     = 1'b0;
    i_rst   = 1'b1;
    i_au    = 4'd15;
    i_bu    = 4'd15;
    i_valid = 1'b1;

    // reset with valid operands pending
    step("rst0", 4'd15, 4'd15, 1'b1, 1'b1);
    step("rst1", 4'd15, 4'd15, 1'b1, 1'b1);
    check_eq("rst_fu_const", {24'b0, o_fu}, 32'h00);
    step("rst_release", 4'd15, 4'd15, 1'b1, 1'b0);
    check_eq("first_after_rst", {24'b0, o_fu}, 32'hE1);

    // directed vectors
    step("d_0x0", 4'd0, 4'd0, 1'b1, 1'b0);
    check_eq("d_0x0_const", {24'b0, o_fu}, 32'h00);
    step("d_15x15", 4'd15, 4'd15, 1'b1, 1'b0);
    check_eq("d_15x15_const", {24'b0, o_fu}, 32'hE1);
    step("d_15x0", 4'd15, 4'd0, 1'b1, 1'b0);
    check_eq("d_15x0_const", {24'b0, o_fu}, 32'h00);
    step("d_5x6", 4'd5, 4'd6, 1'b1, 1'b0);
    check_eq("d_5x6_const", {24'b0, o_fu}, 32'h1E);

    // hold while invalid
    step("hold", 4'd9, 4'd9, 1'b0, 1'b0);
    check_eq("hold_const", {24'b0, o_fu}, 32'h1E);
    step("hold2", 4'd3, 4'd7, 1'b0, 1'b0);

    // back-to-back
    step("b2b0", 4'd3, 4'd4, 1'b1, 1'b0);
    check_eq("b2b0_const", {24'b0, o_fu}, 32'h0C);
    step("b2b1", 4'd7, 4'd7, 1'b1, 1'b0);
    check_eq("b2b1_const", {24'b0, o_fu}, 32'h31);
    step("b2b2", 4'd1, 4'd15, 1'b1, 1'b0);
    check_eq("b2b2_const", {24'b0, o_fu}, 32'h0F);

    // reset collides with 12*11 in flight
    step("mid_rst", 4'd12, 4'd11, 1'b1, 1'b1);
    check_eq("mid_rst_no84", {31'b0, (o_fu == 8'h84)}, 32'h0);
    step("mid_rst2", 4'd12, 4'd11, 1'b0, 1'b0);
    check_eq("mid_rst2_no84", {31'b0, (o_fu == 8'h84)}, 32'h0);

    // exhaustive
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        step("exh", 4'(a), 4'(b), 1'b1, 1'b0);
      end
    end

    // random stream with occasional invalid cycles and resets
    for (int n = 0; n < 300; n++) begin
      step("rnd", 4'($urandom_range(15)), 4'($urandom_range(15)),
           1'($urandom_range(3) != 0), 1'($urandom_range(19) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
